alarm_ctrl_multi: RTL and testbench

Next-generation display/alarm block for the digital clock. It holds NUM_ALARMS independent alarm slots and selects either the current time or any alarm slot for the display. Alarm detection is edge-triggered. A ring/snooze/timeout state machine drives the buzzer. The block sits between the timekeeping counter / alarm registers and the display driver / buzzer.

---
 rtl/alarm_pkg.sv | 34 +++
 rtl/alarm_ctrl_multi_match.sv | 46 ++++
 rtl/alarm_ctrl_multi.sv | 139 +++++++++++++
 tb/tb_alarm_ctrl_multi.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types, default widths and the slot-extraction helper for the alarm block.
package alarm_pkg;

    localparam int unsigned DEF_DIGIT_W = 4;
    localparam int unsigned DEF_DIGITS  = 4;
    localparam int unsigned DEF_TIME_W  = DEF_DIGIT_W * DEF_DIGITS;

    // Upper bounds for the generic slot extractor; callers zero-extend into this width.
    localparam int unsigned MAX_SLOTS  = 16;
    localparam int unsigned MAX_TIME_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRinging,
        StSnoozed
    } alarm_state_e;

    // Returns slot idx (time_w bits wide, zero-padded) from a packed slot vector.
    function automatic logic [MAX_TIME_W-1:0] slot_of(
        input logic [MAX_SLOTS*MAX_TIME_W-1:0] slots,
        input int unsigned                     idx,
        input int unsigned                     time_w
    );
        logic [MAX_SLOTS*MAX_TIME_W-1:0] sh;
        logic [MAX_TIME_W-1:0]           r;
        sh = slots >> (idx * time_w);
        r  = '0;
        for (int unsigned b = 0; b < MAX_TIME_W; b++) begin
            if (b < time_w) r[b] = sh[b];
        end
        return r;
    endfunction

endpackage

// File: rtl/alarm_ctrl_multi_match.sv
// Per-slot comparators, match history and rising-edge trigger with lowest-index priority.
module alarm_ctrl_multi_match #(
    parameter int unsigned NUM_ALARMS = 4,
    parameter int unsigned TIME_W     = 16,
    parameter int unsigned SEL_W      = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [TIME_W-1:0]            current_time,
    input  logic [NUM_ALARMS*TIME_W-1:0] alarm_time,
    input  logic [NUM_ALARMS-1:0]        alarm_en,
    output logic                         trig_any,
    output logic [SEL_W-1:0]             trig_idx
);

    logic [NUM_ALARMS-1:0] match;
    logic [NUM_ALARMS-1:0] match_q;
    logic [NUM_ALARMS-1:0] trig;

    // Live equality of each enabled slot against the current time.
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            match[i] = alarm_en[i] && (current_time == alarm_time[i*TIME_W +: TIME_W]);
        end
    end

    // Only a fresh match fires, so a dismissed alarm stays quiet for the rest of its minute.
    assign trig = match & ~match_q;

    // Lowest set index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        trig_any = |trig;
        trig_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (trig[i]) trig_idx = SEL_W'(i);
        end
    end

    // Match history for edge detection.
    always_ff @(posedge clk) begin
        if (reset) match_q <= '0;
        else       match_q <= match;
    end

endmodule

// File: rtl/alarm_ctrl_multi.sv
// Multi-slot alarm controller: display mux, ring/snooze/timeout FSM and buzzer drive.
module alarm_ctrl_multi
    import alarm_pkg::*;
#(
    parameter  int unsigned DIGIT_W          = DEF_DIGIT_W,
    parameter  int unsigned DIGITS           = DEF_DIGITS,
    parameter  int unsigned NUM_ALARMS       = 4,
    parameter  int unsigned SNOOZE_MIN       = 9,
    parameter  int unsigned RING_TIMEOUT_MIN = 5,
    localparam int unsigned TIME_W           = DIGIT_W * DIGITS,
    localparam int unsigned SEL_W            = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [TIME_W-1:0]            current_time,
    input  logic [NUM_ALARMS*TIME_W-1:0] alarm_time,
    input  logic [NUM_ALARMS-1:0]        alarm_en,
    input  logic                         show_alarm,
    input  logic [SEL_W-1:0]             alarm_sel,
    input  logic                         tick_min,
    input  logic                         snooze,
    input  logic                         alarm_off,
    output logic [TIME_W-1:0]            display_time,
    output logic                         sound_alarm,
    output logic [SEL_W-1:0]             active_alarm,
    output logic                         snoozed
);

    localparam int unsigned RING_W = $clog2(RING_TIMEOUT_MIN + 1);
    localparam int unsigned SNZ_W  = $clog2(SNOOZE_MIN + 1);

    logic                            trig_any;
    logic [SEL_W-1:0]                trig_idx;
    logic [MAX_SLOTS*MAX_TIME_W-1:0] slots_ext;
    logic [TIME_W-1:0]               disp_d, disp_q;
    alarm_state_e                    state_d, state_q;
    logic [SEL_W-1:0]                act_d, act_q;
    logic [RING_W-1:0]               ring_d, ring_q;
    logic [SNZ_W-1:0]                snz_d, snz_q;
    logic                            sound_q, snoozed_q;
    int unsigned                     sel_u;

    alarm_ctrl_multi_match #(
        .NUM_ALARMS (NUM_ALARMS),
        .TIME_W     (TIME_W),
        .SEL_W      (SEL_W)
    ) u_match (
        .clk          (clk),
        .reset        (reset),
        .current_time (current_time),
        .alarm_time   (alarm_time),
        .alarm_en     (alarm_en),
        .trig_any     (trig_any),
        .trig_idx     (trig_idx)
    );

    // Display source select; an out-of-range slot index falls back to the live time.
    always_comb begin
        slots_ext = '0;
        slots_ext[NUM_ALARMS*TIME_W-1:0] = alarm_time;
        sel_u  = 32'(alarm_sel);
        disp_d = current_time;
        if (show_alarm && (sel_u < NUM_ALARMS)) begin
            disp_d = TIME_W'(slot_of(slots_ext, sel_u, TIME_W));
        end
    end

    // Next-state logic: dismiss beats snooze beats timeout; losing the active enable dismisses.
    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        ring_d  = ring_q;
        snz_d   = snz_q;
        unique case (state_q)
            StIdle: begin
                if (trig_any) begin
                    state_d = StRinging;
                    act_d   = trig_idx;
                    ring_d  = '0;
                end
            end
            StRinging: begin
                if (!alarm_en[act_q] || alarm_off) begin
                    state_d = StIdle;
                end else if (snooze) begin
                    state_d = StSnoozed;
                    snz_d   = SNZ_W'(SNOOZE_MIN);
                end else if (tick_min) begin
                    ring_d = ring_q + 1'b1;
                    if (ring_d == RING_W'(RING_TIMEOUT_MIN)) state_d = StIdle;
                end
            end
            StSnoozed: begin
                if (!alarm_en[act_q] || alarm_off) begin
                    state_d = StIdle;
                end else if (trig_any && (trig_idx != act_q)) begin
                    state_d = StRinging;
                    act_d   = trig_idx;
                    ring_d  = '0;
                end else if (tick_min) begin
                    if (snz_q == SNZ_W'(1)) begin
                        state_d = StRinging;
                        ring_d  = '0;
                    end else begin
                        snz_d = snz_q - 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counters and registered output decodes of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            act_q     <= '0;
            ring_q    <= '0;
            snz_q     <= '0;
            disp_q    <= '0;
            sound_q   <= 1'b0;
            snoozed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            act_q     <= act_d;
            ring_q    <= ring_d;
            snz_q     <= snz_d;
            disp_q    <= disp_d;
            sound_q   <= (state_d == StRinging);
            snoozed_q <= (state_d == StSnoozed);
        end
    end

    assign display_time = disp_q;
    assign sound_alarm  = sound_q;
    assign active_alarm = act_q;
    assign snoozed      = snoozed_q;

endmodule

// File: tb/tb_alarm_ctrl_multi.sv
// Randomised and directed bench for alarm_ctrl_multi against a minute-level reference model.
module tb_alarm_ctrl_multi;

    localparam int SNOOZE_MIN       = 9;
    localparam int RING_TIMEOUT_MIN = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] current_time;
    logic [63:0] alarm_time;
    logic [3:0]  alarm_en;
    logic        show_alarm;
    logic [1:0]  alarm_sel;
    logic        tick_min, snooze, alarm_off;
    logic [15:0] display_time;
    logic        sound_alarm;
    logic [1:0]  active_alarm;
    logic        snoozed;

    logic [15:0] display5;
    logic        sound5, snoozed5;
    logic [2:0]  active5;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 = idle, 1 = ringing, 2 = snoozed
    int          m_state, m_act, m_rung, m_left;
    bit [3:0]    m_prev;
    logic [15:0] m_disp;

    always #5 clk = ~clk;

    alarm_ctrl_multi dut (
        .clk          (clk),
        .reset        (reset),
        .current_time (current_time),
        .alarm_time   (alarm_time),
        .alarm_en     (alarm_en),
        .show_alarm   (show_alarm),
        .alarm_sel    (alarm_sel),
        .tick_min     (tick_min),
        .snooze       (snooze),
        .alarm_off    (alarm_off),
        .display_time (display_time),
        .sound_alarm  (sound_alarm),
        .active_alarm (active_alarm),
        .snoozed      (snoozed)
    );

    // Five-slot instance so a select value past the last slot is representable.
    alarm_ctrl_multi #(.NUM_ALARMS(5)) dut5 (
        .clk          (clk),
        .reset        (reset),
        .current_time (current_time),
        .alarm_time   ({16'h0000, alarm_time}),
        .alarm_en     (5'b00000),
        .show_alarm   (1'b1),
        .alarm_sel    (3'd5),
        .tick_min     (1'b0),
        .snooze       (1'b0),
        .alarm_off    (1'b0),
        .display_time (display5),
        .sound_alarm  (sound5),
        .active_alarm (active5),
        .snoozed      (snoozed5)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Applies the spec rules for one clock edge to the model, using the current inputs.
    task automatic model_step();
        bit [3:0] hit, fresh;
        int       w;
        for (int i = 0; i < 4; i++) begin
            hit[i] = alarm_en[i] && (current_time == alarm_time[i*16 +: 16]);
        end
        fresh = hit & ~m_prev;
        w = -1;
        for (int i = 3; i >= 0; i--) if (fresh[i]) w = i;
        if (reset) begin
            m_state = 0; m_act = 0; m_rung = 0; m_left = 0; m_prev = '0; m_disp = '0;
            return;
        end
        m_disp = show_alarm ? alarm_time[alarm_sel*16 +: 16] : current_time;
        m_prev = hit;
        case (m_state)
            0: if (w >= 0) begin m_state = 1; m_act = w; m_rung = 0; end
            1: begin
                if (!alarm_en[m_act] || alarm_off) m_state = 0;
                else if (snooze) begin m_state = 2; m_left = SNOOZE_MIN; end
                else if (tick_min) begin
                    m_rung = m_rung + 1;
                    if (m_rung >= RING_TIMEOUT_MIN) m_state = 0;
                end
            end
            default: begin
                if (!alarm_en[m_act] || alarm_off) m_state = 0;
                else if (w >= 0 && w != m_act) begin m_state = 1; m_act = w; m_rung = 0; end
                else if (tick_min) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin m_state = 1; m_rung = 0; end
                end
            end
        endcase
    endtask

    // One clock: update model, advance, compare every output against the model.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_eq("m_sound", 32'(sound_alarm), 32'(m_state == 1));
        check_eq("m_snoozed", 32'(snoozed), 32'(m_state == 2));
        check_eq("m_active", 32'(active_alarm), 32'(m_act));
        check_eq("m_display", 32'(display_time), 32'(m_disp));
    endtask

    task automatic pulse_tick();
        tick_min = 1'b1; step(); tick_min = 1'b0; step();
    endtask

    initial begin
        logic [15:0] tset [6];
        tset[0] = 16'h0729; tset[1] = 16'h0730; tset[2] = 16'h1200;
        tset[3] = 16'h1203; tset[4] = 16'h0545; tset[5] = 16'h1159;

        reset = 1'b1; current_time = '0; alarm_time = '0; alarm_en = '0;
        show_alarm = 1'b0; alarm_sel = '0; tick_min = 1'b0; snooze = 1'b0; alarm_off = 1'b0;
        m_state = 0; m_act = 0; m_rung = 0; m_left = 0; m_prev = '0; m_disp = '0;
        @(negedge clk);
        step();
        check_eq("rst_sound", 32'(sound_alarm), 32'd0);
        check_eq("rst_display", 32'(display_time), 32'd0);
        check_eq("rst_active", 32'(active_alarm), 32'd0);
        check_eq("rst_snoozed", 32'(snoozed), 32'd0);
        reset = 1'b0;

        // Basic trigger and dismiss
        alarm_time[15:0] = 16'h0730; alarm_en = 4'b0001;
        current_time = 16'h0729; step();
        current_time = 16'h0730; step();
        check_eq("trig_sound", 32'(sound_alarm), 32'd1);
        check_eq("trig_active", 32'(active_alarm), 32'd0);
        alarm_off = 1'b1; step(); alarm_off = 1'b0;
        check_eq("off_sound", 32'(sound_alarm), 32'd0);
        repeat (3) step();
        check_eq("off_stays", 32'(sound_alarm), 32'd0);

        // Snooze for nine minutes then re-ring
        current_time = 16'h0729; step();
        current_time = 16'h0730; step();
        snooze = 1'b1; step(); snooze = 1'b0;
        check_eq("snz_flag", 32'(snoozed), 32'd1);
        check_eq("snz_quiet", 32'(sound_alarm), 32'd0);
        repeat (8) pulse_tick();
        check_eq("snz_8ticks", 32'(snoozed), 32'd1);
        pulse_tick();
        check_eq("rering_sound", 32'(sound_alarm), 32'd1);
        check_eq("rering_snz", 32'(snoozed), 32'd0);

        // Unattended timeout
        repeat (4) pulse_tick();
        check_eq("ring_4ticks", 32'(sound_alarm), 32'd1);
        pulse_tick();
        check_eq("timeout", 32'(sound_alarm), 32'd0);
        check_eq("timeout_snz", 32'(snoozed), 32'd0);

        // Simultaneous triggers and a new slot breaking a snooze
        alarm_time = {16'h1203, 16'h1200, 16'h1200, 16'h0730}; alarm_en = 4'b1110;
        current_time = 16'h1159; step();
        current_time = 16'h1200; step();
        check_eq("prio_active", 32'(active_alarm), 32'd1);
        snooze = 1'b1; step(); snooze = 1'b0;
        current_time = 16'h1203; step();
        check_eq("steal_sound", 32'(sound_alarm), 32'd1);
        check_eq("steal_active", 32'(active_alarm), 32'd3);
        alarm_off = 1'b1; step(); alarm_off = 1'b0;

        // Display path
        alarm_time[47:32] = 16'h0545; show_alarm = 1'b1; alarm_sel = 2'd2; step();
        check_eq("disp_slot2", 32'(display_time), 32'h0545);
        check_eq("disp_oob", 32'(display5), 32'h1203);
        show_alarm = 1'b0; step();
        check_eq("disp_live", 32'(display_time), 32'h1203);

        // Reset while ringing
        alarm_time[15:0] = 16'h0730; alarm_en = 4'b0001;
        current_time = 16'h0729; step();
        current_time = 16'h0730; step();
        check_eq("pre_rst_ring", 32'(sound_alarm), 32'd1);
        reset = 1'b1; step(); reset = 1'b0;
        check_eq("mid_rst_sound", 32'(sound_alarm), 32'd0);
        check_eq("mid_rst_disp", 32'(display_time), 32'd0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 0) begin
                for (int i = 0; i < 4; i++) alarm_time[i*16 +: 16] = tset[$urandom_range(5)];
                alarm_en = 4'($urandom);
            end
            if ($urandom_range(99) < 30) current_time = tset[$urandom_range(5)];
            if ($urandom_range(99) < 2)  alarm_en[$urandom_range(3)] ^= 1'b1;
            tick_min   = ($urandom_range(99) < 25);
            snooze     = ($urandom_range(99) < 5);
            alarm_off  = ($urandom_range(99) < 3);
            reset      = ($urandom_range(999) < 5);
            show_alarm = 1'($urandom);
            alarm_sel  = 2'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
